square_wave_nco_gen: RTL and testbench

Parametrised successor to the fixed 8-bit square generator in the DAC waveform path.
- Frequency comes from a phase accumulator (NCO) instead of a divide counter.
- Duty cycle, high level and low level are programmable.
- New settings arrive through a valid/ready config port and take effect only at a period boundary, so the output never glitches.
- Output feeds the DAC sample mux at one sample per clk.

---
 rtl/square_wave_nco_gen.sv | 134 +++++++++++++
 tb/tb_square_wave_nco_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_nco_gen.sv
// Square-wave NCO: phase accumulator drives a two-level output with programmable duty and levels.
// Latency: wave_data is one clk behind the accumulator value it reflects; period_start/cfg_applied align with it.
// Backpressure: cfg_ready drops while a config waits for the next period boundary; it is never stalled otherwise.
module square_wave_nco_gen #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_fword,
    input  logic [ACC_W-1:0]  cfg_duty,
    input  logic [DATA_W-1:0] cfg_hi,
    input  logic [DATA_W-1:0] cfg_lo,
    output logic [DATA_W-1:0] wave_data,
    output logic              period_start,
    output logic              cfg_applied
);

    localparam logic [DATA_W-1:0] MID      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [ACC_W-1:0]  DUTY_RST = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        RUN_PEND = 2'd2
    } state_t;

    state_t              state;
    logic [ACC_W-1:0]    acc;
    logic                wrap_q;
    logic                applied_q;

    logic [ACC_W-1:0]    fword_a;
    logic [ACC_W-1:0]    duty_a;
    logic [DATA_W-1:0]   hi_a;
    logic [DATA_W-1:0]   lo_a;

    logic [ACC_W-1:0]    fword_p;
    logic [ACC_W-1:0]    duty_p;
    logic [DATA_W-1:0]   hi_p;
    logic [DATA_W-1:0]   lo_p;

    logic                pend;
    logic                hs;
    logic [ACC_W:0]      sum;
    logic                carry;

    assign pend      = (state == RUN_PEND);
    assign cfg_ready = !pend;
    assign hs        = cfg_valid && cfg_ready;
    assign sum       = {1'b0, acc} + {1'b0, fword_a};
    assign carry     = sum[ACC_W];

    // Accumulator, sample generation and config staging; new settings only switch in at a wrap or on leaving RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            acc          <= '0;
            wrap_q       <= 1'b0;
            applied_q    <= 1'b0;
            wave_data    <= MID;
            period_start <= 1'b0;
            cfg_applied  <= 1'b0;
            fword_a      <= '0;
            duty_a       <= DUTY_RST;
            hi_a         <= '1;
            lo_a         <= MID;
            fword_p      <= '0;
            duty_p       <= '0;
            hi_p         <= '0;
            lo_p         <= '0;
        end else begin
            // cfg_applied trails the activation edge so it lines up with the first sample using it
            cfg_applied <= applied_q;
            if (!en) begin
                state        <= IDLE;
                acc          <= '0;
                wrap_q       <= 1'b0;
                wave_data    <= MID;
                period_start <= 1'b0;
                if (pend) begin
                    fword_a   <= fword_p;
                    duty_a    <= duty_p;
                    hi_a      <= hi_p;
                    lo_a      <= lo_p;
                    applied_q <= 1'b1;
                end else if (hs) begin
                    fword_a   <= cfg_fword;
                    duty_a    <= cfg_duty;
                    hi_a      <= cfg_hi;
                    lo_a      <= cfg_lo;
                    applied_q <= 1'b1;
                end else begin
                    applied_q <= 1'b0;
                end
            end else begin
                wave_data    <= (acc < duty_a) ? hi_a : lo_a;
                acc          <= sum[ACC_W-1:0];
                wrap_q       <= carry;
                // First sample after leaving IDLE has acc=0, so it opens a period too
                period_start <= (state == IDLE) || wrap_q;
                applied_q    <= 1'b0;
                case (state)
                    RUN_PEND: begin
                        if (carry) begin
                            fword_a   <= fword_p;
                            duty_a    <= duty_p;
                            hi_a      <= hi_p;
                            lo_a      <= lo_p;
                            applied_q <= 1'b1;
                            state     <= RUN;
                        end
                    end
                    default: begin
                        // A handshake on a wrap edge is only staged; it waits a full period
                        if (hs) begin
                            fword_p <= cfg_fword;
                            duty_p  <= cfg_duty;
                            hi_p    <= cfg_hi;
                            lo_p    <= cfg_lo;
                            state   <= RUN_PEND;
                        end else begin
                            state   <= RUN;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_square_wave_nco_gen.sv
// Directed bench for square_wave_nco_gen at DATA_W=8, ACC_W=8.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// Expected sample values are hand-derived from the accumulator sequence.
module tb_square_wave_nco_gen;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [ACC_W-1:0]  cfg_fword;
    logic [ACC_W-1:0]  cfg_duty;
    logic [DATA_W-1:0] cfg_hi;
    logic [DATA_W-1:0] cfg_lo;
    logic [DATA_W-1:0] wave_data;
    logic              period_start;
    logic              cfg_applied;

    int n_total;
    int n_bad;
    int lo_cnt;
    int ps_cnt;

    square_wave_nco_gen #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_fword    (cfg_fword),
        .cfg_duty     (cfg_duty),
        .cfg_hi       (cfg_hi),
        .cfg_lo       (cfg_lo),
        .wave_data    (wave_data),
        .period_start (period_start),
        .cfg_applied  (cfg_applied)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d want=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int fw, input int du, input int hi, input int lo);
        cfg_fword = ACC_W'(fw);
        cfg_duty  = ACC_W'(du);
        cfg_hi    = DATA_W'(hi);
        cfg_lo    = DATA_W'(lo);
        cfg_valid = 1'b1;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_fword = '0;
        cfg_duty  = '0;
        cfg_hi    = '0;
        cfg_lo    = '0;

        // 1: reset state
        tick();
        tick();
        check("rst_wave", wave_data, 128);
        check("rst_ready", cfg_ready, 1);
        check("rst_ps", period_start, 0);
        check("rst_applied", cfg_applied, 0);
        rst_n = 1'b1;
        tick();
        check("idle_wave", wave_data, 128);

        // 2: IDLE config then run
        offer(64, 128, 200, 50);
        tick();
        cfg_valid = 1'b0;
        check("t2_ready", cfg_ready, 1);
        tick();
        check("t2_applied", cfg_applied, 1);
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t2_wave", wave_data, ((k % 4) < 2) ? 200 : 50);
            check("t2_ps", period_start, (k % 4) == 0);
        end
        tick();
        check("t2_wave8", wave_data, 200);
        check("t2_ps8", period_start, 1);

        // 3: mid-period offer, second offer held off
        offer(32, 64, 255, 0);
        check("t3_ready_pre", cfg_ready, 1);
        tick();
        check("t3_wave9", wave_data, 200);
        check("t3_ready_pend", cfg_ready, 0);
        offer(16, 1, 1, 2);
        tick();
        check("t3_wave10", wave_data, 50);
        check("t3_ready10", cfg_ready, 0);
        tick();
        check("t3_wave11", wave_data, 50);
        check("t3_applied11", cfg_applied, 0);
        check("t3_ready11", cfg_ready, 1);
        cfg_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            check("t3_wave", wave_data, (j < 2) ? 255 : 0);
            check("t3_ps", period_start, j == 0);
            check("t3_applied", cfg_applied, j == 0);
            check("t3_ready", cfg_ready, 1);
        end
        tick();
        check("t3_next_wave", wave_data, 255);
        check("t3_next_ps", period_start, 1);

        // 4: offer on the wrap edge
        for (int i = 1; i < 7; i++) begin
            tick();
            check("t4_pre_wave", wave_data, (i < 2) ? 255 : 0);
        end
        offer(64, 192, 10, 20);
        tick();
        cfg_valid = 1'b0;
        check("t4_wrap_wave", wave_data, 0);
        check("t4_ready", cfg_ready, 0);
        for (int j = 0; j < 8; j++) begin
            tick();
            check("t4_old_wave", wave_data, (j < 2) ? 255 : 0);
            check("t4_old_ps", period_start, j == 0);
            check("t4_old_applied", cfg_applied, 0);
        end
        for (int j = 0; j < 4; j++) begin
            tick();
            check("t4_new_wave", wave_data, (j < 3) ? 10 : 20);
            check("t4_new_ps", period_start, j == 0);
            check("t4_new_applied", cfg_applied, j == 0);
        end

        // 5a: duty=0 gives constant lo
        en = 1'b0;
        tick();
        check("t5_idle_wave", wave_data, 128);
        check("t5_idle_ps", period_start, 0);
        offer(64, 0, 99, 7);
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t5a_wave", wave_data, 7);
            check("t5a_ps", period_start, (k % 4) == 0);
        end

        // 5b: duty=255, fword=1
        en = 1'b0;
        tick();
        offer(1, 255, 255, 0);
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        lo_cnt = 0;
        ps_cnt = 0;
        for (int k = 0; k < 512; k++) begin
            tick();
            if (wave_data == 8'd0) lo_cnt++;
            if (period_start) ps_cnt++;
            if (k == 0 || k == 254 || k == 255 || k == 256 || k == 511)
                check("t5b_wave", wave_data, ((k % 256) == 255) ? 0 : 255);
        end
        check("t5b_lo_cnt", lo_cnt, 2);
        check("t5b_ps_cnt", ps_cnt, 2);

        // 5c: fword=0 freezes output
        en = 1'b0;
        tick();
        offer(0, 128, 33, 44);
        tick();
        cfg_valid = 1'b0;
        en = 1'b1;
        ps_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (period_start) ps_cnt++;
            if (k == 0) check("t5c_ps0", period_start, 1);
        end
        check("t5c_wave", wave_data, 33);
        check("t5c_ps_cnt", ps_cnt, 1);

        // 6a: pending never applies with fword=0 until en drops
        offer(64, 64, 150, 60);
        tick();
        cfg_valid = 1'b0;
        check("t6_ready", cfg_ready, 0);
        check("t6_wave", wave_data, 33);
        tick();
        tick();
        tick();
        check("t6_frozen", wave_data, 33);
        check("t6_no_apply", cfg_applied, 0);
        en = 1'b0;
        tick();
        check("t6_drop_wave", wave_data, 128);
        check("t6_drop_ready", cfg_ready, 1);
        en = 1'b1;
        tick();
        check("t6_run_wave", wave_data, 150);
        check("t6_run_applied", cfg_applied, 1);
        check("t6_run_ps", period_start, 1);
        tick();
        check("t6_run_wave2", wave_data, 60);
        check("t6_run_applied2", cfg_applied, 0);

        // 6b: asynchronous reset with a pending config
        offer(128, 255, 1, 2);
        tick();
        cfg_valid = 1'b0;
        check("t6r_ready_pend", cfg_ready, 0);
        rst_n = 1'b0;
        #1;
        check("t6r_wave", wave_data, 128);
        check("t6r_ready", cfg_ready, 1);
        check("t6r_ps", period_start, 0);
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("t6r_idle_wave", wave_data, 128);
        en = 1'b1;
        tick();
        check("t6r_run_wave", wave_data, 255);
        tick();
        check("t6r_run_wave2", wave_data, 255);
        en = 1'b0;
        tick();
        tick();
        check("t6r_lost", cfg_applied, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
